flash_frame_loader: RTL and testbench

FLASH_FRAME_LOADER -- requirements
Module: flash_frame_loader

---
 rtl/rgb_panel_pkg.sv | 14 +
 rtl/pixel_packer.sv | 33 +++
 rtl/flash_frame_loader.sv | 128 ++++++++++++
 tb/tb_flash_frame_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_panel_pkg.sv
// Shared types for the RGB panel frame path.
// Holds the loader FSM encoding and the pixel width.
package rgb_panel;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CMD  = 2'd2,
    ST_DATA = 2'd3
  } ldr_state_e;

  localparam int PIX_W = 16;

endpackage

// File: rtl/pixel_packer.sv
// Pairs flash bytes into RGB565 pixels.
// The first byte of a pair is the high half; the strobe fires on the second.
module pixel_packer
  import rgb_panel::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [7:0]       byte_i,
  input  logic             valid_i,
  output logic [PIX_W-1:0] pix_o,
  output logic             stb_o
);

  logic       phase_q;
  logic [7:0] hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
    end else if (clr_i) begin
      phase_q <= 1'b0;
    end else if (valid_i) begin
      if (!phase_q) hi_q <= byte_i;
      phase_q <= ~phase_q;
    end
  end

  assign stb_o = valid_i & phase_q & ~clr_i;
  assign pix_o = {hi_q, byte_i};

endmodule

// File: rtl/flash_frame_loader.sv
// Streams one frame, row by row, from SPI flash into a framebuffer.
// Each row is a separate flash read command.
module flash_frame_loader
  import rgb_panel::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'h040000,
  parameter int          N_COLS    = 64,
  parameter int          N_ROWS    = 32,
  localparam int         FB_W      = $clog2(N_COLS * N_ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [7:0]      frame_sel,
  output logic            busy,
  output logic            done,
  output logic [23:0]     fl_addr,
  output logic [15:0]     fl_len,
  output logic            fl_go,
  input  logic            fl_rdy,
  input  logic [7:0]      fl_data,
  input  logic            fl_valid,
  output logic [FB_W-1:0] fb_addr,
  output logic [15:0]     fb_data,
  output logic            fb_we
);

  localparam int COL_W  = $clog2(N_COLS);
  localparam int ROW_W  = $clog2(N_ROWS);
  localparam int ROW_SH = $clog2(N_COLS * 2);
  localparam int FRM_SH = $clog2(N_COLS * N_ROWS * 2);
  localparam logic [15:0] ROW_LEN = 16'(N_COLS * 2);

  ldr_state_e       state_q, state_d;
  logic [7:0]       frame_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [23:0]      fl_addr_q, fl_len_q_ext;
  logic [15:0]      fl_len_q;
  logic [FB_W-1:0]  fb_addr_q;
  logic [15:0]      fb_data_q;
  logic             fb_we_q, done_q;

  logic             accept, in_data, stb;
  logic             col_end, last_row;
  logic [PIX_W-1:0] pix;
  logic [23:0]      cmd_addr;

  assign accept   = (state_q == ST_IDLE) & load;
  assign in_data  = (state_q == ST_DATA);
  assign last_row = (row_q == ROW_W'(N_ROWS - 1));
  assign col_end  = stb & (col_q == COL_W'(N_COLS - 1));

  // Shifts are exact because both frame and row sizes are powers of two.
  assign cmd_addr = BASE_ADDR
                  + (24'(frame_q) << FRM_SH)
                  + (24'(row_q) << ROW_SH);

  pixel_packer u_pack (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (accept),
    .byte_i  (fl_data),
    .valid_i (fl_valid & in_data),
    .pix_o   (pix),
    .stb_o   (stb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (load)   state_d = ST_WAIT;
      ST_WAIT: if (fl_rdy) state_d = ST_CMD;
      ST_CMD:              state_d = ST_DATA;
      ST_DATA: if (col_end) state_d = last_row ? ST_IDLE : ST_WAIT;
      default:             state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q   <= 8'h00;
      row_q     <= '0;
      col_q     <= '0;
      fl_addr_q <= 24'h0;
      fl_len_q  <= 16'h0;
      fb_addr_q <= '0;
      fb_data_q <= 16'h0;
      fb_we_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      fb_we_q <= stb;
      done_q  <= col_end & last_row;
      if (accept) begin
        frame_q <= frame_sel;
        row_q   <= '0;
        col_q   <= '0;
      end
      if ((state_q == ST_WAIT) && fl_rdy) begin
        fl_addr_q <= cmd_addr;
        fl_len_q  <= ROW_LEN;
      end
      if (stb) begin
        fb_data_q <= pix;
        fb_addr_q <= {row_q, col_q};
        col_q     <= col_end ? '0 : col_q + COL_W'(1);
        if (col_end && !last_row) row_q <= row_q + ROW_W'(1);
      end
    end
  end

  assign fl_len_q_ext = {8'h00, fl_len_q};

  assign busy    = (state_q != ST_IDLE);
  assign fl_go   = (state_q == ST_CMD);
  assign done    = done_q;
  assign fl_addr = fl_addr_q;
  assign fl_len  = fl_len_q_ext[15:0];
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;
  assign fb_we   = fb_we_q;

endmodule

// File: tb/tb_flash_frame_loader.sv
// Directed bench: small 4x2 loader instance plus a default-size one.
// Small-instance writes are logged on the falling edge and checked per scenario.
module tb_flash_frame_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance: 4 columns x 2 rows
  logic        rst, s_load, s_rdy, s_valid;
  logic [7:0]  s_sel, s_data;
  logic        s_busy, s_done, s_go, s_we;
  logic [23:0] s_addr;
  logic [15:0] s_len, s_fb_data;
  logic [2:0]  s_fb_addr;

  flash_frame_loader #(.N_COLS(4), .N_ROWS(2)) u_small (
    .clk(clk), .rst(rst), .load(s_load), .frame_sel(s_sel),
    .busy(s_busy), .done(s_done), .fl_addr(s_addr), .fl_len(s_len),
    .fl_go(s_go), .fl_rdy(s_rdy), .fl_data(s_data), .fl_valid(s_valid),
    .fb_addr(s_fb_addr), .fb_data(s_fb_data), .fb_we(s_we)
  );

  // Default instance: 64 x 32
  logic        d_rst, d_load, d_rdy, d_valid;
  logic [7:0]  d_sel, d_data;
  logic        d_busy, d_done, d_go, d_we;
  logic [23:0] d_addr;
  logic [15:0] d_len, d_fb_data;
  logic [10:0] d_fb_addr;

  flash_frame_loader u_dflt (
    .clk(clk), .rst(d_rst), .load(d_load), .frame_sel(d_sel),
    .busy(d_busy), .done(d_done), .fl_addr(d_addr), .fl_len(d_len),
    .fl_go(d_go), .fl_rdy(d_rdy), .fl_data(d_data), .fl_valid(d_valid),
    .fb_addr(d_fb_addr), .fb_data(d_fb_data), .fb_we(d_we)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int done_cnt  = 0;
  int done_good = 0;

  always @(negedge clk) begin
    if (s_we) begin
      wr_addr_q.push_back(s_fb_addr);
      wr_data_q.push_back(s_fb_data);
    end
    if (s_done) begin
      done_cnt++;
      if (s_we && s_fb_addr == 3'd7) done_good++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b0, input int n);
    logic [7:0] b;
    b = b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      b       = b + 8'd1;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic start_load(input logic [7:0] sel);
    @(negedge clk);
    s_load = 1'b1;
    s_sel  = sel;
    @(negedge clk);
    s_load = 1'b0;
  endtask

  task automatic wait_go(output logic ok, output logic [23:0] a,
                         output logic [15:0] len);
    ok  = 1'b0;
    a   = 24'h0;
    len = 16'h0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_go) begin
        ok  = 1'b1;
        a   = s_addr;
        len = s_len;
        break;
      end
    end
  endtask

  task automatic do_row(input string tag, input logic [23:0] exp_a,
                        input logic [7:0] b0);
    logic ok;
    logic [23:0] a;
    logic [15:0] len;
    wait_go(ok, a, len);
    chk({tag, "_go"}, 32'(ok), 32'd1);
    chk({tag, "_addr"}, 32'(a), 32'(exp_a));
    chk({tag, "_len"}, 32'(len), 32'd8);
    send(b0, 8);
  endtask

  task automatic check_frame(input string tag, input int base,
                             input logic [7:0] b0);
    logic [7:0] hi;
    chk({tag, "_wrcnt"}, 32'(wr_addr_q.size() - base), 32'd8);
    if (wr_addr_q.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) begin
        hi = b0 + 8'(2 * i);
        chk({tag, "_wa"}, 32'(wr_addr_q[base+i]), 32'(i));
        chk({tag, "_wd"}, 32'(wr_data_q[base+i]),
            32'({hi, hi + 8'd1}));
      end
    end
  endtask

  int base, dc, dg;
  logic        ok;
  logic [23:0] ga;
  logic [15:0] gl;

  initial begin
    rst = 1'b1; s_load = 1'b0; s_sel = 8'h00;
    s_rdy = 1'b1; s_valid = 1'b0; s_data = 8'h00;
    d_rst = 1'b1; d_load = 1'b0; d_sel = 8'h00;
    d_rdy = 1'b1; d_valid = 1'b0; d_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_done", 32'(s_done), 0);
    chk("rst_go", 32'(s_go), 0);
    chk("rst_we", 32'(s_we), 0);
    chk("rst_addr", 32'(s_addr), 0);
    chk("rst_len", 32'(s_len), 0);
    chk("rst_fba", 32'(s_fb_addr), 0);
    chk("rst_fbd", 32'(s_fb_data), 0);
    rst = 1'b0;
    d_rst = 1'b0;

    // Basic frame 0, bytes 00..0F
    base = wr_addr_q.size(); dc = done_cnt; dg = done_good;
    start_load(8'd0);
    chk("s1_busy", 32'(s_busy), 1);
    do_row("s1_r0", 24'h040000, 8'h00);
    do_row("s1_r1", 24'h040008, 8'h08);
    repeat (3) @(negedge clk);
    check_frame("s1", base, 8'h00);
    chk("s1_done", 32'(done_cnt - dc), 1);
    chk("s1_done_we7", 32'(done_good - dg), 1);
    chk("s1_idle", 32'(s_busy), 0);
    chk("s1_hold_addr", 32'(s_addr), 32'h040008);

    // Default parameters, frame 3
    @(negedge clk);
    d_load = 1'b1; d_sel = 8'd3;
    @(negedge clk);
    d_load = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (d_go) begin ok = 1'b1; ga = d_addr; gl = d_len; end
    end
    chk("s2_go0", 32'(ok), 1);
    chk("s2_addr0", 32'(ga), 32'h043000);
    chk("s2_len", 32'(gl), 32'd128);
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      d_valid = 1'b1;
      d_data  = 8'(i);
    end
    @(negedge clk);
    d_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (d_go) begin ok = 1'b1; ga = d_addr; end
      else @(negedge clk);
    end
    chk("s2_go1", 32'(ok), 1);
    chk("s2_addr1", 32'(ga), 32'h043080);
    d_rst = 1'b1;

    // Flash not ready for 20 cycles
    base = wr_addr_q.size(); dc = done_cnt;
    s_rdy = 1'b0;
    start_load(8'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("s3_nogo", 32'(s_go), 0);
      chk("s3_busy", 32'(s_busy), 1);
    end
    s_rdy = 1'b1;
    @(negedge clk);
    chk("s3_go", 32'(s_go), 1);
    chk("s3_addr", 32'(s_addr), 32'h040010);
    send(8'h60, 8);
    do_row("s3_r1", 24'h040018, 8'h68);
    repeat (3) @(negedge clk);
    check_frame("s3", base, 8'h60);
    chk("s3_done", 32'(done_cnt - dc), 1);

    // Load again mid-DATA with another frame
    base = wr_addr_q.size(); dc = done_cnt;
    start_load(8'd0);
    wait_go(ok, ga, gl);
    chk("s4_go", 32'(ok), 1);
    chk("s4_addr0", 32'(ga), 32'h040000);
    send(8'h80, 3);
    s_load = 1'b1; s_sel = 8'd5;
    @(negedge clk);
    s_load = 1'b0;
    send(8'h83, 5);
    do_row("s4_r1", 24'h040008, 8'h88);
    repeat (5) @(negedge clk);
    check_frame("s4", base, 8'h80);
    chk("s4_done", 32'(done_cnt - dc), 1);

    // Reset after three pixels of row 0
    base = wr_addr_q.size(); dc = done_cnt;
    start_load(8'd0);
    wait_go(ok, ga, gl);
    chk("s5_go", 32'(ok), 1);
    send(8'hA0, 6);
    #2 rst = 1'b1;
    #1;
    chk("s5_we", 32'(s_we), 0);
    chk("s5_busy", 32'(s_busy), 0);
    chk("s5_addr", 32'(s_addr), 0);
    chk("s5_len", 32'(s_len), 0);
    chk("s5_fba", 32'(s_fb_addr), 0);
    chk("s5_fbd", 32'(s_fb_data), 0);
    send(8'hA6, 4);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("s5_wrcnt", 32'(wr_addr_q.size() - base), 3);
    chk("s5_nodone", 32'(done_cnt - dc), 0);
    base = wr_addr_q.size(); dc = done_cnt;
    start_load(8'd0);
    do_row("s5_r0", 24'h040000, 8'h20);
    do_row("s5_r1", 24'h040008, 8'h28);
    repeat (3) @(negedge clk);
    check_frame("s5b", base, 8'h20);
    chk("s5_done", 32'(done_cnt - dc), 1);

    // Stray bytes in IDLE and WAIT
    base = wr_addr_q.size(); dc = done_cnt;
    s_rdy = 1'b0;
    send(8'hAA, 1);
    start_load(8'd0);
    send(8'hBB, 1);
    s_rdy = 1'b1;
    do_row("s6_r0", 24'h040000, 8'h40);
    s_rdy = 1'b0;
    send(8'hCC, 1);
    s_rdy = 1'b1;
    do_row("s6_r1", 24'h040008, 8'h48);
    repeat (3) @(negedge clk);
    check_frame("s6", base, 8'h40);
    chk("s6_done", 32'(done_cnt - dc), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
